// File: rtl/debounce_pkg.sv
// ============================================================================
// Module      : debounce_pkg
// Description : Shared state encoding and helpers for the debounce channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

    localparam logic [1:0] ST_STABLE_LO = 2'b00;
    localparam logic [1:0] ST_PEND_HI   = 2'b01;
    localparam logic [1:0] ST_STABLE_HI = 2'b11;
    localparam logic [1:0] ST_PEND_LO   = 2'b10;

    localparam int MIN_DEB_CYCLES  = 2;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    typedef enum logic [1:0] {
        STABLE_LO = ST_STABLE_LO,
        PEND_HI   = ST_PEND_HI,
        STABLE_HI = ST_STABLE_HI,
        PEND_LO   = ST_PEND_LO
    } deb_state_e;

    // Resting state that corresponds to a given debounced level.
    function automatic deb_state_e idle_state(input logic level);
        return level ? STABLE_HI : STABLE_LO;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_ch.sv
// ============================================================================
// Module      : debounce_ch
// Description : One channel: input synchroniser, debounce FSM and counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_ch
    import debounce_pkg::*;
#(
    parameter int   DEB_CYCLES  = 4,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_i,
    output logic signal_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW      = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;

    deb_state_e    state_q;
    deb_state_e    state_n;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_n;
    logic          level_q;
    logic          level_n;
    logic          rise_q;
    logic          rise_n;
    logic          fall_q;
    logic          fall_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{INIT_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= idle_state(INIT_VAL);
            cnt_q   <= '0;
            level_q <= INIT_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            level_q <= level_n;
            rise_q  <= rise_n;
            fall_q  <= fall_n;
        end
    end

    // The counter is only advanced while pending and is cleared on every
    // exit from a pending state, so it stops at CNT_MAX and never wraps.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        level_n = level_q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (sample) begin
                    state_n = PEND_HI;
                    cnt_n   = '0;
                end
            end
            PEND_HI: begin
                if (!sample) begin
                    state_n = STABLE_LO;
                    cnt_n   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_n = STABLE_HI;
                    cnt_n   = '0;
                    level_n = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            STABLE_HI: begin
                if (!sample) begin
                    state_n = PEND_LO;
                    cnt_n   = '0;
                end
            end
            PEND_LO: begin
                if (sample) begin
                    state_n = STABLE_HI;
                    cnt_n   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_n = STABLE_LO;
                    cnt_n   = '0;
                    level_n = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            default: begin
                state_n = idle_state(level_q);
                cnt_n   = '0;
            end
        endcase
    end

    assign signal_o = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

`default_nettype wire

// File: rtl/debounce_array.sv
// ============================================================================
// Module      : debounce_array
// Description : N_CH independent debounced inputs with edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_array
    import debounce_pkg::*;
#(
    parameter int              N_CH        = 4,
    parameter int              CLK_FREQ    = 100_000_000,
    parameter int              DEB_HZ      = 1000,
    parameter int              SYNC_STAGES = 2,
    parameter logic [N_CH-1:0] INIT_VAL    = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] signal_i,
    output logic [N_CH-1:0] signal_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic            any_edge_o
);

    localparam int DEB_CYCLES = CLK_FREQ / DEB_HZ;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DEB_CYCLES  (DEB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES),
            .INIT_VAL    (INIT_VAL[i])
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .signal_i (signal_i[i]),
            .signal_o (signal_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i])
        );
    end

    // Pulses are already registered per channel; this OR adds no latency.
    assign any_edge_o = |(rise_o | fall_o);

endmodule

`default_nettype wire

// File: tb/tb_debounce_array.sv
// ============================================================================
// Module      : tb_debounce_array
// Description : Randomised and directed bench for debounce_array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_array;

    localparam int              N_CH     = 4;
    localparam int              CLK_FREQ = 4;
    localparam int              DEB_HZ   = 1;
    localparam int              SYNC     = 2;
    localparam int              DEB      = CLK_FREQ / DEB_HZ;
    localparam int              LAT      = SYNC + DEB + 1;
    localparam logic [N_CH-1:0] INIT     = '0;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] sig;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            any_edge;

    always #5 clk = ~clk;

    debounce_array #(
        .N_CH        (N_CH),
        .CLK_FREQ    (CLK_FREQ),
        .DEB_HZ      (DEB_HZ),
        .SYNC_STAGES (SYNC),
        .INIT_VAL    (INIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_i   (raw),
        .signal_o   (sig),
        .rise_o     (rise),
        .fall_o     (fall),
        .any_edge_o (any_edge)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: a channel flips once the synchronised sample has disagreed
    // with the debounced level on DEB+1 consecutive edges.
    logic [N_CH-1:0] m_out;
    logic [N_CH-1:0] m_rise;
    logic [N_CH-1:0] m_fall;
    int              run [N_CH];
    logic [N_CH-1:0] dly [$];

    function automatic void model_reset();
        dly.delete();
        for (int k = 0; k < SYNC; k++) dly.push_back(INIT);
        m_out  = INIT;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < N_CH; c++) run[c] = 0;
    endfunction

    function automatic void model_edge(input logic [N_CH-1:0] now_raw);
        logic [N_CH-1:0] s;
        s = dly.pop_front();
        dly.push_back(now_raw);
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (s[c] != m_out[c]) begin
                run[c]++;
                if (run[c] == DEB + 1) begin
                    m_out[c] = s[c];
                    if (s[c]) m_rise[c] = 1'b1;
                    else      m_fall[c] = 1'b1;
                    run[c] = 0;
                end
            end else begin
                run[c] = 0;
            end
        end
    endfunction

    task automatic check_all();
        check_val("signal_o", 32'(sig), 32'(m_out));
        check_val("rise_o", 32'(rise), 32'(m_rise));
        check_val("fall_o", 32'(fall), 32'(m_fall));
        check_val("any_edge_o", 32'(any_edge), 32'(|(m_rise | m_fall)));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge(raw);
        #1;
        check_all();
    endtask

    // Called at posedge+1: asserts rst mid-cycle, releases it on a negedge.
    task automatic async_reset();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        check_val("rst_rise_zero", 32'(rise), 32'(0));
        check_val("rst_sig_init", 32'(sig), 32'(INIT));
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic measure(input int ch, input bit want_rise, output int edges);
        int extra;
        edges = -1;
        for (int i = 1; i <= 3 * LAT; i++) begin
            step();
            if ((want_rise ? rise[ch] : fall[ch]) === 1'b1) begin
                edges = i;
                break;
            end
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rise[ch] === 1'b1 || fall[ch] === 1'b1) extra++;
        end
        check_val("single_pulse", 32'(extra), 32'(0));
    endtask

    initial begin
        int edges;
        int pulses;
        int hold [N_CH];

        rst = 1'b1;
        raw = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();

        // Two channels rising together, exact latency and one-cycle pulses.
        raw = 4'b1001;
        edges = -1;
        for (int i = 1; i <= 3 * LAT; i++) begin
            step();
            if (i == LAT - 1) check_val("ch0_not_yet", 32'(sig[0]), 32'(0));
            if (rise[0] === 1'b1) begin
                edges = i;
                check_val("rise_pair", 32'(rise), 32'(4'b1001));
                check_val("any_high", 32'(any_edge), 32'(1));
                break;
            end
        end
        check_val("lat_ch0_rise", 32'(edges), 32'(LAT));
        step();
        check_val("rise_one_cycle", 32'(rise), 32'(0));
        check_val("any_one_cycle", 32'(any_edge), 32'(0));

        // Short pulse on ch1 is rejected.
        pulses = 0;
        raw[1] = 1'b1;
        repeat (3) begin
            step();
            pulses += int'(rise[1] | fall[1]);
        end
        raw[1] = 1'b0;
        repeat (12) begin
            step();
            pulses += int'(rise[1] | fall[1]);
        end
        check_val("ch1_glitch_pulses", 32'(pulses), 32'(0));
        check_val("ch1_glitch_level", 32'(sig[1]), 32'(0));

        // Bounce on ch2, then held high.
        for (int k = 0; k < 4; k++) begin
            raw[2] = (k % 2 == 0);
            step();
        end
        raw[2] = 1'b1;
        measure(2, 1'b1, edges);
        check_val("lat_ch2_bounce", 32'(edges), 32'(LAT));

        // Falling edge from STABLE_HI on ch0.
        raw[0] = 1'b0;
        measure(0, 1'b0, edges);
        check_val("lat_ch0_fall", 32'(edges), 32'(LAT));
        check_val("ch0_low", 32'(sig[0]), 32'(0));

        // Reset in the middle of PEND_HI on ch1, then normal debounce.
        raw[1] = 1'b1;
        repeat (4) step();
        async_reset();
        measure(1, 1'b1, edges);
        check_val("lat_after_rst", 32'(edges), 32'(LAT));

        // Random hold lengths around the debounce threshold.
        for (int c = 0; c < N_CH; c++) hold[c] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (hold[c] == 0) begin
                    raw[c]  = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 2 * LAT));
                end
                hold[c]--;
            end
            step();
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debounce_array.md
DEBOUNCE_ARRAY -- requirements
Module: debounce_array

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels, 1..32.
REQ-002 Parameter CLK_FREQ, default 100_000_000: clk frequency in Hz.
REQ-003 Parameter DEB_HZ, default 1000: debounce rate; DEB_CYCLES = CLK_FREQ/DEB_HZ (localparam), SHALL be >= 2.
REQ-004 Parameter SYNC_STAGES, default 2: synchroniser depth per channel, 2..4.
REQ-005 Parameter INIT_VAL, default {N_CH{1'b0}}: per-channel idle level after reset.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 signal_i  input  N_CH  raw asynchronous inputs (buttons/switches), one bit per channel.
REQ-009 signal_o  output  N_CH  debounced level per channel.
REQ-010 rise_o  output  N_CH  one-cycle pulse when the signal_o bit goes 0->1.
REQ-011 fall_o  output  N_CH  one-cycle pulse when the signal_o bit goes 1->0.
REQ-012 any_edge_o  output  1  OR of all rise_o and fall_o bits, same cycle.

Function
REQ-013 Each channel SHALL pass signal_i through SYNC_STAGES flops; the last stage is the sample s used by the FSM.
REQ-014 Each channel SHALL run an FSM with states STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-015 STABLE_LO: s=1 -> PEND_HI, counter cleared to 0; otherwise remain. STABLE_HI is symmetric (s=0 -> PEND_LO).
REQ-016 PEND_HI: s=0 -> STABLE_LO, counter cleared, no output change (glitch rejected).
REQ-017 PEND_HI with s=1: counter == DEB_CYCLES-1 -> STABLE_HI, signal_o bit set, rise_o pulsed, counter cleared; otherwise counter increments.
REQ-018 PEND_LO is symmetric to PEND_HI, with signal_o cleared and fall_o pulsed.
REQ-019 Latency: a clean raw transition SHALL appear on signal_o after exactly SYNC_STAGES+DEB_CYCLES+1 rising edges.
REQ-020 signal_o SHALL be 1 in STABLE_HI and PEND_LO and 0 in STABLE_LO and PEND_HI, registered.
REQ-021 rise_o/fall_o SHALL be registered, high for exactly one cycle, and never both high on the same channel.
REQ-022 The counter width SHALL be $clog2(DEB_CYCLES) bits; the counter never exceeds DEB_CYCLES-1 and never wraps.
REQ-023 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 An input toggling every cycle or more often than every DEB_CYCLES+1 cycles SHALL never change signal_o.

Reset
REQ-025 While rst=1, each channel SHALL hold: sync flops = INIT_VAL bit, state = STABLE_HI or STABLE_LO per the INIT_VAL bit, counter = 0, signal_o = INIT_VAL, rise_o = fall_o = any_edge_o = 0.
REQ-026 rst asserted mid-debounce SHALL abort the pending transition with no pulse.
REQ-027 After rst deassertion, a raw level differing from INIT_VAL SHALL be debounced normally (full latency, with pulse).

Structure
REQ-028 The FSM state encoding (2-bit localparams) SHALL live in the shared package debounce_pkg.
REQ-029 The per-channel sync+FSM+counter SHALL be the sub-module debounce_ch, instantiated N_CH times by generate; debounce_array adds only the any_edge_o OR.

Verification (CLK_FREQ=4, DEB_HZ=1 -> DEB_CYCLES=4, SYNC_STAGES=2, N_CH=4, INIT_VAL=0)
REQ-030 Ch0 raw 0->1 held: signal_o[0] rises after edge 7; rise_o[0] and any_edge_o high for that one cycle only.
REQ-031 Ch1 raw high for 3 cycles, then low: signal_o[1] stays 0; no pulses.
REQ-032 Ch2 bounce 1,0,1,0,1 (1 cycle each), then held 1: single rise_o[2] exactly 7 edges after the final 0->1.
REQ-033 Ch0 and ch3 rise on the same edge: rise_o[0] and rise_o[3] pulse together; any_edge_o is a single one-cycle pulse.
REQ-034 rst asserted asynchronously (between edges) during PEND_HI: outputs return to 0 immediately; no pulse; after release with raw still 1, rise occurs 7 edges later.
REQ-035 Ch0 at STABLE_HI, raw 1->0 held: fall_o[0] pulses once; signal_o[0]=0 after edge 7.
